hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage CPU. It drives the enables, bubble and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory misses through a request/ready handshake, and keeps saturating stall and flush statistics counters.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the zero
// register constant and the priority-ordered hazard encoding.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Higher encoding wins: miss > load-use > branch flush > none.
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_FLUSH    = 2'd1,
        HZ_LOAD_USE = 2'd2,
        HZ_MISS     = 2'd3
    } hazard_e;

    function automatic hazard_e hz_encode(input logic miss, input logic load_use,
                                          input logic branch);
        if (miss)          return HZ_MISS;
        else if (load_use) return HZ_LOAD_USE;
        else if (branch)   return HZ_FLUSH;
        else               return HZ_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes and
// data-memory miss freezes with a request/ready handshake and a miss timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memrd_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_access_i,
    input  logic             mem_hit_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             id_ex_bubble_o,
    output logic             if_id_flush_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e            state, next_state;
    hazard_e           hz;
    logic              load_use, miss, timed_out, err_q;
    logic [WAIT_W-1:0] wait_cnt;

    always_comb begin
        miss     = (state == RUN) && mem_access_i && !mem_hit_i;
        load_use = ex_memrd_i && (ex_rt_i != REG_ZERO) &&
                   ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        hz       = hz_encode(miss, load_use, id_branch_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= RUN;
        else        state <= next_state;
    end

    always_comb begin
        next_state     = state;
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        mem_req_o      = 1'b0;
        if (state == MEM_WAIT && !mem_ready_i) begin
            mem_req_o = 1'b1;
        end else begin
            // The release cycle behaves like RUN without a miss.
            if (state == MEM_WAIT) next_state = RUN;
            case (hz)
                HZ_MISS: begin
                    mem_req_o  = 1'b1;
                    next_state = MEM_WAIT;
                end
                HZ_LOAD_USE: begin
                    id_ex_en_o     = 1'b1;
                    ex_mem_en_o    = 1'b1;
                    mem_wb_en_o    = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
                default: begin
                    pc_en_o       = 1'b1;
                    if_id_en_o    = 1'b1;
                    id_ex_en_o    = 1'b1;
                    ex_mem_en_o   = 1'b1;
                    mem_wb_en_o   = 1'b1;
                    if_id_flush_o = (hz == HZ_FLUSH);
                end
            endcase
        end
        if (!rst_i) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_en_o    = 1'b0;
            id_ex_bubble_o = 1'b0;
            if_id_flush_o  = 1'b0;
            mem_req_o      = 1'b0;
        end
    end

    assign timed_out = (state == MEM_WAIT) && (wait_cnt == WAIT_MAX);
    assign err_o     = err_q || timed_out;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == MEM_WAIT && next_state == MEM_WAIT && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else if (next_state == RUN)
                wait_cnt <= '0;
            if (timed_out) err_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (!pc_en_o),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (if_id_flush_o),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
    logic       id_uses_rt_i = 1'b0, ex_memrd_i = 1'b0, id_branch_taken_i = 1'b0;
    logic       mem_access_i = 1'b0, mem_hit_i = 1'b0, mem_ready_i = 1'b0;
    logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
    logic       id_ex_bubble_o, if_id_flush_o, mem_req_o, err_o;
    logic [2:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.CNT_W(3), .TIMEOUT(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_memrd_i(ex_memrd_i), .ex_rt_i(ex_rt_i),
        .id_branch_taken_i(id_branch_taken_i),
        .mem_access_i(mem_access_i), .mem_hit_i(mem_hit_i), .mem_ready_i(mem_ready_i),
        .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
        .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
        .id_ex_bubble_o(id_ex_bubble_o), .if_id_flush_o(if_id_flush_o),
        .mem_req_o(mem_req_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush, req, err}
    localparam logic [8:0] E_OFF  = 9'b000000000;
    localparam logic [8:0] E_RUN  = 9'b111110000;
    localparam logic [8:0] E_LU   = 9'b001111000;
    localparam logic [8:0] E_BR   = 9'b111110100;
    localparam logic [8:0] E_MISS = 9'b000000010;
    localparam logic [8:0] E_ERR  = 9'b000000001;

    typedef struct {
        logic [8:0] ctrl;
        logic [2:0] st;
        logic [2:0] fl;
        int         row;
    } exp_t;

    exp_t sb[$];
    int   total = 0, passed = 0, row = 0;

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic memrd, input logic [4:0] exrt,
                        input logic br, input logic acc, input logic hit, input logic rdy,
                        input logic [8:0] c, input int st, input int fl);
        exp_t e;
        rst_i = r; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses;
        ex_memrd_i = memrd; ex_rt_i = exrt; id_branch_taken_i = br;
        mem_access_i = acc; mem_hit_i = hit; mem_ready_i = rdy;
        e.ctrl = c; e.st = 3'(st); e.fl = 3'(fl); e.row = row;
        sb.push_back(e);
        row++;
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
                   id_ex_bubble_o, if_id_flush_o, mem_req_o, err_o};
            total++;
            if (act !== e.ctrl) $display("FAIL ctrl row %0d: got %b want %b", e.row, act, e.ctrl);
            else passed++;
            total++;
            if (stall_cnt_o !== e.st) $display("FAIL stall_cnt row %0d: got %0d want %0d", e.row, stall_cnt_o, e.st);
            else passed++;
            total++;
            if (flush_cnt_o !== e.fl) $display("FAIL flush_cnt row %0d: got %0d want %0d", e.row, flush_cnt_o, e.fl);
            else passed++;
        end
    end

    initial begin
        @(posedge clk_i);
        #1;
        // reset, even with a miss and branch present
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_OFF, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
        // load-use via rs, zero register, unused rt, used rt
        step(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, E_LU,  0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN, 1, 0);
        step(1, 3, 9, 0, 1, 9, 0, 0, 0, 0, E_RUN, 1, 0);
        step(1, 3, 9, 1, 1, 9, 0, 0, 0, 0, E_LU,  1, 0);
        step(1, 9, 0, 0, 0, 9, 0, 0, 0, 0, E_RUN, 2, 0);
        // branch flush; branch with load-use defers the flush
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR,  2, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 2, 1);
        step(1, 8, 0, 0, 1, 8, 1, 0, 0, 0, E_LU,  2, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR,  3, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 3, 2);
        // asynchronous clear of counters
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 0);
        // miss with ready after 3 wait cycles
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 2, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_RUN,  4, 0);
        // ready in RUN ignored, hit is not a miss
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN,  4, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RUN,  4, 0);
        // branch during miss: flush in the release cycle, 1-cycle penalty
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_MISS, 4, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, E_BR,   5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  5, 1);
        // reset in 2nd MEM_WAIT cycle
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 5, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 6, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_OFF,  0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  0, 0);
        // timeout: err on the 6th MEM_WAIT cycle, sticky past ready
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MISS, 0, 0);
        for (int i = 1; i <= 6; i++)
            step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, (i == 6) ? (E_MISS | E_ERR) : E_MISS, i, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_RUN | E_ERR, 7, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN | E_ERR, 7, 0);
        // reset clears err; then saturation of both counters
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 0);
        for (int i = 0; i < 10; i++)
            step(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, E_LU, (i > 7) ? 7 : i, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 7, 0);
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR, 7, (i > 7) ? 7 : i);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 7, 7);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_i);
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
